// File: rtl/grf_scoreboard_pkg.sv
// Shared definitions for the GRF scoreboard slice.
//   - REG_ZERO: hard-wired zero register address
//   - DEFAULT_DATA_W / DEFAULT_ADDR_W: default register geometry
//   - dec_width(): width needed to count simultaneous writebacks
//   - `GRF_SLICE(bus, idx, w): selects element idx of a flattened port bus
//   - `GRF_TRACE_FMT: writeback trace line format ($time, pc, reg, data),
//     used only when GRF_TRACE_EN is defined
`ifndef GRF_SCOREBOARD_PKG_SV
`define GRF_SCOREBOARD_PKG_SV

`define GRF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`define GRF_TRACE_FMT "%d@%h: $%d <= %h"

package grf_scoreboard_pkg;
  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG_ZERO       = 0;

  function automatic int dec_width(input int num_wr);
    return $clog2(num_wr + 1);
  endfunction
endpackage

`endif

// File: rtl/grf_pend_ctr.sv
// Pending-producer counter for one register.
//   clk, reset : clock, synchronous active-high reset
//   flush      : clear the count at the next edge (wins over inc/dec)
//   inc        : one producer issues this cycle
//   dec        : number of writebacks retiring this cycle
//   net        : count after this cycle's writebacks, clamped at 0
//                (drives busy/ready decisions in the same cycle)
module grf_pend_ctr
  import grf_scoreboard_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int DEC_W  = dec_width(2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inc,
  input  logic [DEC_W-1:0]  dec,
  output logic [PEND_W-1:0] net
);

  localparam int CMP_W = (PEND_W > DEC_W) ? PEND_W : DEC_W;

  logic [PEND_W-1:0] count = '0;
  logic [CMP_W-1:0]  count_x;
  logic [CMP_W-1:0]  dec_x;

  always_comb begin
    count_x = CMP_W'(count);
    dec_x   = CMP_W'(dec);
    net     = '0;
    // Spurious writebacks clamp at zero instead of wrapping.
    if (count_x > dec_x) net = PEND_W'(count_x - dec_x);
  end

  always_ff @(posedge clk) begin
    if (reset || flush)
      count <= '0;
    else if (inc && (net != {PEND_W{1'b1}}))
      count <= net + PEND_W'(1);
    else
      count <= net;
  end

endmodule

// File: rtl/grf_scoreboard.sv
// Parametrised MIPS general register file with write-to-read forwarding and
// a per-register pending-write scoreboard for the hazard unit.
//   clk, reset   : clock, synchronous active-high reset
//   rd_addr      : NUM_RD flattened read addresses
//   rd_data      : NUM_RD flattened read data (combinational, forwarded)
//   rd_busy      : operand still has a producer in flight after this
//                  cycle's writebacks
//   wr_en/addr/data : NUM_WR writeback ports, higher index wins
//   wr_pc        : retiring PC per write port, trace only
//   issue_en/addr: D-stage instruction claiming a destination register
//   issue_ready  : destination counter has room; issue accepted
//   flush        : drop all pending counts at the next edge
// Optional: define GRF_TRACE_EN to print one trace line per written register.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int PEND_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     flush
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DEC_W = dec_width(NUM_WR);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_A   = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Per-register view of this cycle's writebacks: winning data and how many
  // ports retire into it. Register 0 never registers a hit.
  logic [DEPTH-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEC_W-1:0]  wr_dec [DEPTH];
  logic [PEND_W-1:0] pend_net [DEPTH];

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      wr_dec[r] = '0;
      if (r != REG_ZERO) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (`GRF_SLICE(wr_addr, p, ADDR_W) == ADDR_W'(r))) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = `GRF_SLICE(wr_data, p, DATA_W);
            wr_dec[r] = wr_dec[r] + DEC_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++)
        if (wr_hit[r]) mem[r] <= wr_val[r];
    end
  end

  assign pend_net[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_pend
    grf_pend_ctr #(
      .PEND_W (PEND_W),
      .DEC_W  (DEC_W)
    ) u_ctr (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .inc   (issue_en && issue_ready && (issue_addr == ADDR_W'(r))),
      .dec   (wr_dec[r]),
      .net   (pend_net[r])
    );
  end

  assign issue_ready = reset || (issue_addr == ZERO_A) ||
                       (pend_net[issue_addr] != PEND_MAX);

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = `GRF_SLICE(rd_addr, i, ADDR_W);
      if (!reset && (a != ZERO_A)) begin
        `GRF_SLICE(rd_data, i, DATA_W) = wr_hit[a] ? wr_val[a] : mem[a];
        rd_busy[i] = (pend_net[a] != '0);
      end
    end
  end

`ifdef GRF_TRACE_EN
  logic [31:0] wr_win_pc [DEPTH];

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      wr_win_pc[r] = '0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && (`GRF_SLICE(wr_addr, p, ADDR_W) == ADDR_W'(r)))
          wr_win_pc[r] = `GRF_SLICE(wr_pc, p, 32);
    end
  end

  always @(posedge clk) begin
    if (!reset)
      for (int r = 1; r < DEPTH; r++)
        if (wr_hit[r])
          $display(`GRF_TRACE_FMT, $time, wr_win_pc[r], ADDR_W'(r), wr_val[r]);
  end
`else
  logic unused_pc;
  assign unused_pc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_pc;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        flush;

  int n_assert = 0;
  int n_fail   = 0;

  grf_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_pc       (wr_pc),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 2'b00; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
    wr_pc = {32'h0040_0104, 32'h0040_0100};
  endtask

  task automatic iss(input logic [4:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  initial begin
    reset = 1'b1; idle(); rd(5'd5, 5'd3);
    wr_addr = '0; wr_data = '0; wr_pc = '0; issue_addr = 5'd8;
    #1;
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_rd1", rd_data[63:32], 32'h0);
    chk("reset_busy", rd_busy, 2'b00);
    chk("reset_ready", issue_ready, 1'b1);
    cyc(); cyc();
    reset = 1'b0;

    // Forwarding and port priority
    wr(2'b11, 5'd5, 32'h1111_1111, 5'd5, 32'h2222_2222); rd(5'd5, 5'd0); #1;
    chk("fwd_prio", rd_data[31:0], 32'h2222_2222);
    cyc(); idle(); #1;
    chk("store_prio", rd_data[31:0], 32'h2222_2222);
    wr(2'b11, 5'd6, 32'h0000_00A6, 5'd7, 32'h0000_00B7); rd(5'd1, 5'd2); #1;
    cyc(); idle(); rd(5'd6, 5'd7); #1;
    chk("store_p0", rd_data[31:0], 32'h0000_00A6);
    chk("store_p1", rd_data[63:32], 32'h0000_00B7);

    // Register zero
    wr(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd1, 32'h0); wr_en = 2'b01; iss(5'd0); rd(5'd0, 5'd0); #1;
    chk("r0_fwd", rd_data, 64'h0);
    chk("r0_busy", rd_busy, 2'b00);
    chk("r0_ready", issue_ready, 1'b1);
    cyc(); idle(); #1;
    chk("r0_store", rd_data, 64'h0);
    chk("r0_busy_after", rd_busy, 2'b00);

    // Saturation on $8
    rd(5'd8, 5'd0);
    for (int k = 0; k < 3; k++) begin
      iss(5'd8); #1;
      chk("sat_fill_ready", issue_ready, 1'b1);
      cyc();
    end
    iss(5'd8); #1;
    chk("sat_full_ready", issue_ready, 1'b0);
    chk("sat_full_busy", rd_busy[0], 1'b1);
    cyc();
    iss(5'd8); wr(2'b01, 5'd8, 32'h88, 5'd0, 32'h0); #1;
    chk("sat_wb_ready", issue_ready, 1'b1);
    chk("sat_wb_busy", rd_busy[0], 1'b1);
    cyc(); idle(); iss(5'd8); #1;
    chk("sat_still_full", issue_ready, 1'b0);
    cyc(); idle();
    wr(2'b11, 5'd8, 32'h81, 5'd8, 32'h82); #1;
    chk("drain2_busy", rd_busy[0], 1'b1);
    cyc(); wr(2'b01, 5'd8, 32'h83, 5'd0, 32'h0); #1;
    chk("drain1_busy", rd_busy[0], 1'b0);
    chk("drain1_fwd", rd_data[31:0], 32'h83);
    cyc(); idle(); #1;
    chk("drained_busy", rd_busy[0], 1'b0);

    // Simultaneous issue and retire on $9
    rd(5'd0, 5'd9); iss(5'd9); #1;
    chk("sim_issue_own_busy", rd_busy[1], 1'b0);
    cyc(); idle(); #1;
    chk("sim_pending", rd_busy[1], 1'b1);
    iss(5'd9); wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h99); #1;
    chk("sim_busy_now", rd_busy[1], 1'b0);
    chk("sim_ready", issue_ready, 1'b1);
    cyc(); idle(); #1;
    chk("sim_busy_next", rd_busy[1], 1'b1);
    wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h9A); cyc(); idle();
    wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h9B); cyc(); idle(); #1;
    chk("clamp_busy", rd_busy[1], 1'b0);
    chk("clamp_data", rd_data[63:32], 32'h9B);

    // Flush with pending counts
    iss(5'd3); cyc(); iss(5'd3); cyc(); iss(5'd4); cyc(); idle();
    rd(5'd3, 5'd4); #1;
    chk("pre_flush_busy", rd_busy, 2'b11);
    flush = 1'b1; iss(5'd3); wr(2'b01, 5'd3, 32'h7, 5'd0, 32'h0); #1;
    cyc(); idle(); #1;
    chk("flush_busy", rd_busy, 2'b00);
    chk("flush_data", rd_data[31:0], 32'h7);

    // Reset mid-operation
    wr(2'b01, 5'd10, 32'hAAAA_0010, 5'd0, 32'h0); cyc(); idle();
    iss(5'd10); cyc(); idle(); rd(5'd10, 5'd11); #1;
    chk("pre_rst_busy", rd_busy, 2'b01);
    chk("pre_rst_data", rd_data[31:0], 32'hAAAA_0010);
    reset = 1'b1; iss(5'd10); wr(2'b11, 5'd10, 32'h1, 5'd11, 32'h55); #1;
    chk("rst_rd", rd_data, 64'h0);
    chk("rst_busy", rd_busy, 2'b00);
    chk("rst_ready", issue_ready, 1'b1);
    cyc(); reset = 1'b0; idle(); issue_addr = 5'd10; #1;
    chk("post_rst_rd", rd_data, 64'h0);
    chk("post_rst_busy", rd_busy, 2'b00);
    chk("post_rst_ready", issue_ready, 1'b1);
    rd(5'd5, 5'd3); #1;
    chk("post_rst_r5", rd_data, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
